// File: rtl/opfetch_seq_if.sv
// Memory read bus and indexed-address adder handshake shared by the operand-fetch sequencer.
// master = sequencer side, slave = memory/adder side.
interface opfetch_seq_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mc;
    logic [2:0]  adas;
    logic [15:0] calc_mdb;
    logic [15:0] sout;
    logic [15:0] dout;
    logic [15:0] calc_out;
    logic        calc_done;

    modport master (
        output mem_addr, mem_rd, mc, adas, calc_mdb, sout, dout,
        input  mem_ack, mem_rdata, calc_out, calc_done
    );

    modport slave (
        input  mem_addr, mem_rd, mc, adas, calc_mdb, sout, dout,
        output mem_ack, mem_rdata, calc_out, calc_done
    );
endinterface

// File: rtl/opfetch_seq.sv
// Format I operand-fetch sequencer: extension-word reads, indexed-address adder handshake
// and operand reads, producing src_op/dst_op for the execute stage.
module opfetch_seq #(
    parameter int CALC_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  as_mode,
    input  logic        ad_mode,
    input  logic [15:0] sreg_val,
    input  logic [15:0] dreg_val,
    input  logic [15:0] pc_val,
    output logic        pc_inc,
    output logic        sreg_inc,
    opfetch_seq_if.master bus,
    output logic [15:0] src_op,
    output logic [15:0] dst_op,
    output logic [15:0] dst_addr,
    output logic        dst_is_mem,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] S_EXT  = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_READ = 3'd3;
    localparam logic [2:0] D_EXT  = 3'd4;
    localparam logic [2:0] D_CALC = 3'd5;
    localparam logic [2:0] D_READ = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    localparam int CW = $clog2(CALC_TIMEOUT + 1);

    logic [2:0]    state;
    logic [1:0]    as_q;
    logic          ad_q;
    logic [15:0]   sreg_q, dreg_q, src_addr, mdb_q;
    logic [CW-1:0] calc_cnt;

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign bus.calc_mdb = mdb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            as_q       <= '0;
            ad_q       <= 1'b0;
            sreg_q     <= '0;
            dreg_q     <= '0;
            src_addr   <= '0;
            mdb_q      <= '0;
            calc_cnt   <= '0;
            src_op     <= '0;
            dst_op     <= '0;
            dst_addr   <= '0;
            dst_is_mem <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Counter only advances inside a calc state; it restarts at 0 on every entry.
            calc_cnt <= '0;
            case (state)
                IDLE: if (start) begin
                    as_q   <= as_mode;
                    ad_q   <= ad_mode;
                    sreg_q <= sreg_val;
                    dreg_q <= dreg_val;
                    case (as_mode)
                        2'b01: state <= S_EXT;
                        2'b10, 2'b11: begin
                            src_addr <= sreg_val;
                            state    <= S_READ;
                        end
                        default: begin
                            src_op <= sreg_val;
                            if (ad_mode) state <= D_EXT;
                            else begin
                                dst_op     <= dreg_val;
                                dst_is_mem <= 1'b0;
                                dst_addr   <= '0;
                                state      <= DONE;
                            end
                        end
                    endcase
                end
                S_EXT, D_EXT: if (bus.mem_ack) begin
                    mdb_q <= bus.mem_rdata;
                    state <= (state == S_EXT) ? S_CALC : D_CALC;
                end
                S_CALC, D_CALC: begin
                    // calc_done is ignored in the first cycle of a calc state.
                    if (calc_cnt != '0 && bus.calc_done) begin
                        if (state == S_CALC) begin
                            src_addr <= bus.calc_out;
                            state    <= S_READ;
                        end else begin
                            dst_addr   <= bus.calc_out;
                            dst_is_mem <= 1'b1;
                            state      <= D_READ;
                        end
                    end else if (calc_cnt == CW'(CALC_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        calc_cnt <= calc_cnt + CW'(1);
                    end
                end
                S_READ: if (bus.mem_ack) begin
                    src_op <= bus.mem_rdata;
                    if (ad_q) state <= D_EXT;
                    else begin
                        dst_op     <= dreg_q;
                        dst_is_mem <= 1'b0;
                        dst_addr   <= '0;
                        state      <= DONE;
                    end
                end
                D_READ: if (bus.mem_ack) begin
                    dst_op <= bus.mem_rdata;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus strobes are decoded from state (and mem_ack) so a reset leaves them all low.
    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_addr = '0;
        bus.mc       = 1'b0;
        bus.adas     = '0;
        bus.sout     = '0;
        bus.dout     = '0;
        pc_inc       = 1'b0;
        sreg_inc     = 1'b0;
        case (state)
            S_EXT, D_EXT: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pc_val;
                pc_inc       = bus.mem_ack;
            end
            S_CALC: begin
                bus.mc   = 1'b1;
                bus.adas = 3'b001;
                bus.sout = sreg_q;
            end
            D_CALC: begin
                bus.mc   = 1'b1;
                bus.adas = 3'b100;
                bus.dout = dreg_q;
            end
            S_READ: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = src_addr;
                sreg_inc     = bus.mem_ack && (as_q == 2'b11);
            end
            D_READ: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = dst_addr;
            end
            default: ;
        endcase
    end
endmodule
